// File: rtl/usb_buf_pkg.sv
// Shared definitions for the USB endpoint data buffer: AHB transfer-size
// encoding, its byte-count decode, and the default buffer depth.
package usb_buf_pkg;

    localparam int DEFAULT_DEPTH = 64;

    typedef enum logic [1:0] {
        SIZE_1B = 2'd0,
        SIZE_2B = 2'd1,
        SIZE_3B = 2'd2,
        SIZE_4B = 2'd3
    } data_size_t;

    // Byte count moved by one AHB access of the given size (1..4).
    function automatic logic [2:0] decode_size(input data_size_t size);
        return {1'b0, size} + 3'd1;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/occupancy bookkeeping for the byte FIFO: decides whether each
// requested write/read fits, advances the pointers and latches error flags.
module fifo_ptr_ctrl
    import usb_buf_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int OW = AW + 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clear,
    input  logic          wr_req,
    input  logic [2:0]    wr_size,
    input  logic          rd_req,
    input  logic [2:0]    rd_size,
    output logic [AW-1:0] wptr,
    output logic [AW-1:0] rptr,
    output logic [OW-1:0] occupancy,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underflow,
    output logic          wr_accept,
    output logic          rd_accept
);

    logic [OW-1:0] free_space;
    logic [OW-1:0] wr_amt;
    logic [OW-1:0] rd_amt;

    // Both checks use the pre-edge occupancy so a read and a write landing
    // in the same cycle never depend on each other.
    always_comb begin
        free_space = OW'(DEPTH) - occupancy;
        wr_accept  = !clear && wr_req && (free_space >= OW'(wr_size));
        rd_accept  = !clear && rd_req && (occupancy >= OW'(rd_size));
        wr_amt     = wr_accept ? OW'(wr_size) : '0;
        rd_amt     = rd_accept ? OW'(rd_size) : '0;
        full       = (occupancy == OW'(DEPTH));
        empty      = (occupancy == '0);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr      <= wptr + AW'(wr_amt);
            rptr      <= rptr + AW'(rd_amt);
            occupancy <= occupancy + wr_amt - rd_amt;
            if (wr_req && !wr_accept) begin
                overflow <= 1'b1;
            end
            if (rd_req && !rd_accept) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_data_fifo.sv
// USB endpoint data buffer: circular byte store shared between the RX byte
// port / AHB word writer and the AHB word reader / TX byte port.
module usb_data_fifo
    import usb_buf_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WORD_BYTES = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int OW = AW + 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    buffer_reserved,
    input  logic                    store_rx_packet_data,
    input  logic [7:0]              rx_packet_data,
    input  logic                    store_tx_data,
    input  logic [8*WORD_BYTES-1:0] tx_data,
    input  logic                    get_rx_data,
    input  logic [1:0]              data_size,
    input  logic                    get_tx_packet_data,
    output logic [8*WORD_BYTES-1:0] rx_data,
    output logic [7:0]              tx_packet_data,
    output logic [OW-1:0]           buffer_occupancy,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic                    underflow
);

    logic [7:0]              mem [DEPTH];
    logic [2:0]              ahb_size;
    logic [2:0]              wr_size;
    logic [2:0]              rd_size;
    logic                    wr_req;
    logic                    rd_req;
    logic [8*WORD_BYTES-1:0] wr_word;
    logic [AW-1:0]           wptr;
    logic [AW-1:0]           rptr;
    logic                    wr_accept;
    logic                    rd_accept;

    // Only the side owning the buffer may write; the AHB reader outranks TX.
    always_comb begin
        ahb_size = decode_size(data_size_t'(data_size));
        wr_req   = buffer_reserved ? store_rx_packet_data : store_tx_data;
        wr_size  = buffer_reserved ? 3'd1 : ahb_size;
        wr_word  = buffer_reserved ? {{(8*WORD_BYTES-8){1'b0}}, rx_packet_data} : tx_data;
        rd_req   = get_rx_data | get_tx_packet_data;
        rd_size  = get_rx_data ? ahb_size : 3'd1;
    end

    fifo_ptr_ctrl #(
        .DEPTH(DEPTH)
    ) u_ptr_ctrl (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (clear),
        .wr_req    (wr_req),
        .wr_size   (wr_size),
        .rd_req    (rd_req),
        .rd_size   (rd_size),
        .wptr      (wptr),
        .rptr      (rptr),
        .occupancy (buffer_occupancy),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow),
        .wr_accept (wr_accept),
        .rd_accept (rd_accept)
    );

    // Bytes stored while reset is held stay invisible: pointers and
    // occupancy remain at zero, so the access never completes.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (k < int'(wr_size)) begin
                    mem[wptr + AW'(k)] <= wr_word[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        rx_data        = '0;
        tx_packet_data = '0;
        if (!empty) begin
            tx_packet_data = mem[rptr];
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (k < int'(ahb_size)) begin
                    rx_data[8*k +: 8] = mem[rptr + AW'(k)];
                end
            end
        end
    end

endmodule

// File: doc/usb_data_fifo.md
USB_DATA_FIFO -- requirements
Module: usb_data_fifo

Interface
REQ-001 Parameter DEPTH, 64, buffer capacity in bytes; SHALL be a power of 2, 8..256.
REQ-002 Parameter WORD_BYTES, 4, AHB-side word width in bytes; SHALL be 4 in this generation.
REQ-003 Localparam AW = clog2(DEPTH); occupancy width OW = AW+1.
REQ-004 clk  input  1  clock, rising-edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 clear  input  1  synchronous flush, from protocol controller.
REQ-007 buffer_reserved  input  1  write-port owner: 1 = RX byte port, 0 = AHB word port.
REQ-008 store_rx_packet_data  input  1  RX byte-write strobe.
REQ-009 rx_packet_data  input  8  RX write byte.
REQ-010 store_tx_data  input  1  AHB write strobe.
REQ-011 tx_data  input  32  AHB write word, little-endian.
REQ-012 get_rx_data  input  1  AHB read (pop) strobe.
REQ-013 data_size  input  2  AHB transfer size: 0=1B, 1=2B, 2=3B, 3=4B.
REQ-014 get_tx_packet_data  input  1  TX byte-read (pop) strobe.
REQ-015 rx_data  output  32  AHB read word, show-ahead.
REQ-016 tx_packet_data  output  8  TX read byte, show-ahead.
REQ-017 buffer_occupancy  output  OW  stored byte count, 0..DEPTH.
REQ-018 full, empty  output  1 each  occupancy==DEPTH / occupancy==0.
REQ-019 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-020 Storage SHALL be a circular byte array with AW-bit write/read pointers wrapping modulo DEPTH; multi-byte accesses SHALL wrap across index DEPTH-1 to 0.
REQ-021 Write size SHALL be 1 for an RX write (store_rx_packet_data & buffer_reserved) and data_size+1 for an AHB write (store_tx_data & !buffer_reserved); strobes from the non-owning side SHALL be ignored.
REQ-022 AHB write SHALL place tx_data[8k+7:8k] at wptr+k for k < size.
REQ-023 Read port: get_rx_data pops data_size+1 bytes; else get_tx_packet_data pops 1 byte; AHB SHALL win if both asserted.
REQ-024 rx_data byte k SHALL equal mem[rptr+k] for k < data_size+1, upper bytes zero; tx_packet_data SHALL equal mem[rptr]; both zero when empty; zero latency (combinational from state).
REQ-025 A write SHALL be accepted only if free space (DEPTH - occupancy) >= size; otherwise nothing written, pointers unchanged, overflow set.
REQ-026 A read SHALL be accepted only if occupancy >= size; otherwise pointers unchanged, underflow set.
REQ-027 Acceptance SHALL use pre-edge occupancy; simultaneous accepted read and write in one cycle SHALL both complete, occupancy += wsize - rsize.
REQ-028 buffer_occupancy SHALL be a registered counter updated in the same edge as the pointers (no one-cycle lag), never exceeding DEPTH.
REQ-029 clear SHALL have priority over all strobes: pointers, occupancy, overflow, underflow to 0 next edge; array contents need not be cleared.
REQ-030 overflow/underflow SHALL stay set until clear or reset.

Reset
REQ-031 On n_rst low: pointers, buffer_occupancy, overflow, underflow = 0; empty=1, full=0; rx_data=0, tx_packet_data=0; array contents need not be reset.
REQ-032 Reset asserted mid-transfer SHALL discard the in-flight access with no partial write.

Structure
REQ-033 Package usb_buf_pkg SHALL hold the data_size encoding enum, size-decode function, and DEFAULT_DEPTH.
REQ-034 One sub-module fifo_ptr_ctrl SHALL own pointers, occupancy, accept logic and error flags; top holds the array and byte lanes.

Verification
REQ-035 Reset, AHB write 0xDDCCBBAA size 3, then 4 TX pops -> bytes AA,BB,CC,DD; occupancy 4->0; empty=1.
REQ-036 DEPTH=64: 64 RX writes then one more -> full=1, occupancy 64, 65th rejected, overflow=1.
REQ-037 wptr=rptr=62, AHB write 0x44332211 size 3 then AHB read size 3 -> rx_data 0x44332211 (wrap 63->0).
REQ-038 Occupancy 2, AHB read size 3 -> rejected, underflow=1, occupancy stays 2; AHB read size 1 -> 2 bytes, upper rx_data bytes 0.
REQ-039 Occupancy 10, same-cycle RX write and TX pop -> occupancy 10; clear with strobes asserted -> occupancy 0, flags 0.
